// File: rtl/seq_mult_if.sv
// Handshake and operand/product bundle for seq_mult: the requester drives start/tc/x/y,
// the multiplier returns busy/done/out.
interface seq_mult_if #(
    parameter int N = 8
) ();
    logic           start;
    logic           tc;
    logic [N-1:0]   x;
    logic [N-1:0]   y;
    logic           busy;
    logic           done;
    logic [2*N-1:0] out;

    modport master (output start, output tc, output x, output y,
                    input  busy,  input  done, input out);
    modport slave  (input  start, input  tc, input  x, input  y,
                    output busy,  output done, output out);
endinterface

// File: rtl/seq_mult.sv
// Iterative shift-add N x N -> 2N multiplier, unsigned or two's-complement per operation.
// Define EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
module seq_mult #(
    parameter int N = 8
) (
    input  logic       clk,
    input  logic       reset,
    seq_mult_if.slave  bus
);
    localparam int             CW       = $clog2(N);
    localparam logic [CW-1:0]  CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [2*N-1:0] ONE2     = {{(2*N-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t         state_r;
    logic [N-1:0]   mcand_r;
    logic [N-1:0]   mplier_r;
    logic [2*N-1:0] acc_r;
    logic [CW-1:0]  cnt_r;
    logic           neg_r;
    logic           busy_r;
    logic           done_r;
    logic [2*N-1:0] out_r;

    logic [2*N-1:0] addend_s;
    logic [2*N-1:0] acc_next_s;
    logic [N-1:0]   mplier_next_s;
    logic           last_s;
    logic [2*N-1:0] result_s;

    // Magnitude of a two's-complement operand; -2^(N-1) maps to 2^(N-1), which still fits unsigned.
    function automatic logic [N-1:0] magnitude(input logic [N-1:0] v, input logic is_tc);
        return (is_tc && v[N-1]) ? (~v + {{(N-1){1'b0}}, 1'b1}) : v;
    endfunction

    // One shift-add step and the completion decision for the current BUSY cycle.
    always_comb begin
        addend_s      = {{N{1'b0}}, mcand_r} << cnt_r;
        mplier_next_s = mplier_r >> 1;
        if (mplier_r[0]) begin
            acc_next_s = acc_r + addend_s;
        end else begin
            acc_next_s = acc_r;
        end
`ifdef EARLY_TERM_EN
        last_s = (cnt_r == CNT_LAST) || (mplier_next_s == {N{1'b0}});
`else
        last_s = (cnt_r == CNT_LAST);
`endif
        if (neg_r) begin
            result_s = ~acc_next_s + ONE2;
        end else begin
            result_s = acc_next_s;
        end
    end

    // Control FSM and datapath registers; all outputs come straight from flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            mcand_r  <= {N{1'b0}};
            mplier_r <= {N{1'b0}};
            acc_r    <= {(2*N){1'b0}};
            cnt_r    <= {CW{1'b0}};
            neg_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            out_r    <= {(2*N){1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        mcand_r  <= magnitude(bus.x, bus.tc);
                        mplier_r <= magnitude(bus.y, bus.tc);
                        neg_r    <= bus.tc & (bus.x[N-1] ^ bus.y[N-1]);
                        acc_r    <= {(2*N){1'b0}};
                        cnt_r    <= {CW{1'b0}};
                        state_r  <= BUSY;
                        busy_r   <= 1'b1;
                    end
                end
                BUSY: begin
                    acc_r    <= acc_next_s;
                    mplier_r <= mplier_next_s;
                    cnt_r    <= cnt_r + CNT_ONE;
                    if (last_s) begin
                        out_r   <= result_s;
                        done_r  <= 1'b1;
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.out  = out_r;
endmodule

// File: tb/tb_seq_mult.sv
// Scoreboard bench for seq_mult: directed N=8 vectors (both modes, handshake corner cases,
// mid-operation reset) plus an N=4 unsigned sweep against x*y.
module tb_seq_mult;
    logic clk;
    logic reset;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    typedef struct {
        logic [15:0] val;
        int          due;
        int          lat;
    } exp_t;

    exp_t        q8[$];
    logic [7:0]  q4[$];
    logic [15:0] last8 = 16'h0000;
    int          busy_cnt = 0;

`ifdef EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    seq_mult_if #(.N(8)) bus8 ();
    seq_mult_if #(.N(4)) bus4 ();

    seq_mult #(.N(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
    seq_mult #(.N(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected cycle count for an 8-bit operation.
    function automatic int lat8(input logic tc, input logic [7:0] y);
        logic [7:0] m;
        int l;
        m = (tc && y[7]) ? (8'h00 - y) : y;
        l = 1;
        for (int i = 0; i < 8; i++) if (m[i]) l = i + 1;
        return EARLY ? l : 8;
    endfunction

    // Called just after a negedge with the DUT idle at the coming edge.
    task automatic issue8(input logic tc, input logic [7:0] x, input logic [7:0] y,
                          input logic [15:0] exp);
        exp_t e;
        bus8.tc = tc; bus8.x = x; bus8.y = y; bus8.start = 1'b1;
        e.val = exp; e.due = cyc + 1 + lat8(tc, y); e.lat = lat8(tc, y);
        q8.push_back(e);
        @(negedge clk); #1;
        bus8.start = 1'b0;
        bus8.tc = ~tc; bus8.x = ~x; bus8.y = ~y;
    endtask

    task automatic issue4(input logic [3:0] x, input logic [3:0] y, input logic [7:0] exp);
        bus4.tc = 1'b0; bus4.x = x; bus4.y = y; bus4.start = 1'b1;
        q4.push_back(exp);
        @(negedge clk); #1;
        bus4.start = 1'b0;
        bus4.x = ~x; bus4.y = ~y;
    endtask

    task automatic drain(input bit four);
        int k = 0;
        while (((four ? q4.size() : q8.size()) != 0) && k < 100) begin
            @(negedge clk); #1;
            k++;
        end
        if ((four ? q4.size() : q8.size()) != 0) begin
            tests++; fails++;
            $display("FAIL drain_timeout: %0d results still pending (cycle %0d)",
                     four ? q4.size() : q8.size(), cyc);
            q4.delete(); q8.delete();
        end
    endtask

    // N=8 monitor: result value, delivery cycle, busy width, and out holding between results.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (reset) begin
            busy_cnt = 0;
            last8 = 16'h0000;
        end else begin
            if (bus8.busy) busy_cnt++;
            if (bus8.done) begin
                if (q8.size() == 0) begin
                    chk("unexpected_done8", 32'd1, 32'd0);
                end else begin
                    e = q8.pop_front();
                    chk("out8", bus8.out, e.val);
                    chk("done_cycle8", cyc, e.due);
                    chk("busy_width8", busy_cnt, e.lat);
                    chk("busy_at_done8", bus8.busy, 1'b0);
                    last8 = e.val;
                end
                busy_cnt = 0;
            end else begin
                chk("out_hold8", bus8.out, last8);
            end
        end
    end

    // N=4 monitor.
    initial forever begin
        @(negedge clk);
        if (!reset && bus4.done) begin
            if (q4.size() == 0) chk("unexpected_done4", 32'd1, 32'd0);
            else chk("out4", bus4.out, q4.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset = 1'b1;
        bus8.start = 1'b0; bus8.tc = 1'b0; bus8.x = 8'h00; bus8.y = 8'h00;
        bus4.start = 1'b0; bus4.tc = 1'b0; bus4.x = 4'h0; bus4.y = 4'h0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        chk("rst_busy", bus8.busy, 1'b0);
        chk("rst_done", bus8.done, 1'b0);
        chk("rst_out", bus8.out, 16'h0000);

        issue8(1'b0, 8'hFF, 8'hFF, 16'hFE01); drain(1'b0);
        issue8(1'b1, 8'hFD, 8'h05, 16'hFFF1); drain(1'b0);
        issue8(1'b1, 8'h80, 8'h80, 16'h4000); drain(1'b0);
        issue8(1'b1, 8'h03, 8'hFE, 16'hFFFA); drain(1'b0);
        issue8(1'b0, 8'h80, 8'h02, 16'h0100); drain(1'b0);
        issue8(1'b1, 8'h7F, 8'h7F, 16'h3F01); drain(1'b0);
        issue8(1'b1, 8'hFF, 8'h80, 16'h0080); drain(1'b0);
        issue8(1'b0, 8'h12, 8'h01, 16'h0012); drain(1'b0);
        issue8(1'b0, 8'h12, 8'h00, 16'h0000); drain(1'b0);
        issue8(1'b0, 8'h12, 8'h10, 16'h0120); drain(1'b0);

        // Stray start while busy is dropped; a start in the done cycle is taken.
        issue8(1'b0, 8'h0C, 8'h0A, 16'h0078);
        @(negedge clk); #1;
        bus8.tc = 1'b0; bus8.x = 8'h03; bus8.y = 8'h03; bus8.start = 1'b1;
        @(negedge clk); #1;
        bus8.start = 1'b0;
        k = 0;
        while (!bus8.done && k < 50) begin
            @(negedge clk); #1;
            k++;
        end
        chk("done_seen_b2b", bus8.done, 1'b1);
        issue8(1'b0, 8'h05, 8'h07, 16'h0023);
        drain(1'b0);

        // Reset after the third iteration aborts at once.
        issue8(1'b0, 8'h55, 8'hAA, 16'h3872);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", bus8.busy, 1'b0);
        chk("abort_done", bus8.done, 1'b0);
        chk("abort_out", bus8.out, 16'h0000);
        q8.delete();
        @(negedge clk); #1;
        reset = 1'b0;
        issue8(1'b0, 8'h0B, 8'h0D, 16'h008F); drain(1'b0);

        issue4(4'hF, 4'hF, 8'hE1); drain(1'b1);
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                issue4(4'(a), 4'(b), 8'(a * b));
                drain(1'b1);
            end
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/seq_mult.md
# seq_mult

Parametrised iterative shift-add multiplier producing a 2N-bit product from two N-bit operands. Supports an unsigned mode and a two's-complement mode, selected per operation. It uses a start/busy/done handshake and finishes in at most N cycles. It is the sequential, width-generic successor to the fixed 4x4 combinational CSA/CPA array multiplier, for datapaths where area matters more than single-cycle latency.

## Interface
- N, 8, operand width in bits; legal range N >= 2
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  request a multiply; sampled only in IDLE
- tc  input  1  0 = unsigned operands, 1 = two's-complement operands; latched with start
- x  input  N  multiplicand; latched with start
- y  input  N  multiplier; latched with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse: out is valid and was just updated
- out  output  2N  product; holds its value until the next completion or reset

## Operation
- FSM has two states, IDLE and BUSY. Reset enters IDLE.
- IDLE, start=1 at a rising edge:
  - mcand <= |x| and mplier <= |y|, where magnitudes apply only when tc=1; otherwise the raw values.
  - neg <= tc & (x[N-1] ^ y[N-1]).
  - acc <= 0, cnt <= 0, state <= BUSY.
- BUSY, each edge:
  - If mplier[0] = 1, then acc <= acc + (mcand << cnt). acc is 2N bits wide, and |x|,|y| <= 2^(N-1) fit in N unsigned bits.
  - mplier <= mplier >> 1; cnt <= cnt + 1.
- Completion edge is the edge with cnt = N-1. On that edge:
  - out <= neg ? -(acc_next) : acc_next, using 2N-bit two's-complement negation.
  - done <= 1, state <= IDLE.
- start in BUSY is ignored. It is not queued.
- x, y and tc changes after the start edge have no effect.
- Signed overflow is impossible. The most extreme case is (-2^(N-1))^2 = 2^(2N-2), which fits in 2N bits.

## Timing
- Reset values:
  - state = IDLE, busy = 0, done = 0, out = 0.
  - acc, mcand, mplier, cnt and neg are all 0.
- busy = (state == BUSY). It rises the cycle after the start edge and falls in the same cycle done rises.
- Latency: start accepted at edge E0, iterations at E1..EN, and out/done are valid in the cycle after EN. That is N cycles from the accept edge, or fewer with EARLY_TERM_EN.
- done is high for exactly one cycle. In every other cycle done = 0.
- Back-to-back operation: the FSM is in IDLE during the done cycle, so a start asserted in that cycle is accepted.
  - out keeps the previous result until the new operation completes.
- Reset asserted mid-operation aborts immediately and asynchronously. No done pulse is produced and out returns to 0.
- Throughput: one result per N+1 cycles when start is held high.

## Configuration
- EARLY_TERM_EN defined:
  - On any BUSY edge where the shifted mplier would become 0, that edge is the completion edge.
  - This includes the first BUSY edge when y = 0.
  - Latency becomes max(1, floor(log2(|y|)) + 1) cycles.
- EARLY_TERM_EN undefined: latency is always exactly N cycles. The results are identical in both builds.

## Test plan
- N=8, tc=0, x=0xFF, y=0xFF -> done 8 cycles after the accept edge, out=0xFE01, busy high for exactly 8 cycles.
- N=8, tc=1, x=0xFD (-3), y=0x05 -> out=0xFFF1 (-15). Also x=0x80, y=0x80 -> out=0x4000.
- N=4, tc=0, x=0xF, y=0xF -> out=0xE1, matching the 4x4 array multiplier. Sweep all 256 operand pairs and compare against the behavioural x*y.
- Pulse start again two cycles into BUSY with different operands -> ignored, and the first result is delivered unchanged. Then start in the done cycle -> accepted, and the second result follows N+1 cycles after the first.
- Assert reset at iteration 3 of 8 -> busy=0, out=0 and done=0 asynchronously. The next start after release completes normally.
- With EARLY_TERM_EN: y=0x01 -> done after 1 cycle; y=0x00 -> 1 cycle with out=0; y=0x10 -> 5 cycles. Without the macro, all three take 8 cycles and give the same out values.
